// File: rtl/rob_buffer.sv
// Reorder buffer: circular entry store with in-order allocate/commit, out-of-order
// completion, and two bypassed operand read ports.
module rob_rd_lane #(
  parameter int ROB_SIZE = 8,
  parameter int VAL_W    = 64,
  parameter int FLAG_W   = 4,
  parameter int NUM_CPL  = 2,
  parameter int TAG_W    = 3
) (
  input  logic [TAG_W-1:0]                 rdTag,
  input  logic [ROB_SIZE-1:0]              busy,
  input  logic [ROB_SIZE-1:0]              done,
  input  logic [ROB_SIZE-1:0][VAL_W-1:0]   value,
  input  logic [ROB_SIZE-1:0][FLAG_W-1:0]  flags,
  input  logic [NUM_CPL-1:0]               cplValid,
  input  logic [NUM_CPL-1:0][TAG_W-1:0]    cplTag,
  input  logic [NUM_CPL-1:0][VAL_W-1:0]    cplValue,
  input  logic [NUM_CPL-1:0][FLAG_W-1:0]   cplFlags,
  output logic                             rdDone,
  output logic [VAL_W-1:0]                 rdValue,
  output logic [FLAG_W-1:0]                rdFlags
);
  // Ascending scan so the highest-indexed matching port ends up winning.
  always_comb begin
    rdDone  = done[rdTag];
    rdValue = value[rdTag];
    rdFlags = flags[rdTag];
    for (int p = 0; p < NUM_CPL; p++) begin
      if (busy[rdTag] && cplValid[p] && cplTag[p] == rdTag) begin
        rdDone  = 1'b1;
        rdValue = cplValue[p];
        rdFlags = cplFlags[p];
      end
    end
  end
endmodule

module rob_buffer #(
  parameter int ROB_SIZE = 8,
  parameter int VAL_W    = 64,
  parameter int FLAG_W   = 4,
  parameter int MGMT_W   = 9,
  parameter int NUM_CPL  = 2,
  localparam int TAG_W   = $clog2(ROB_SIZE)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             alloc_valid_i,
  input  logic [MGMT_W-1:0]                alloc_mgmt_i,
  output logic                             alloc_ready_o,
  output logic [TAG_W-1:0]                 alloc_tag_o,
  input  logic [NUM_CPL-1:0]               cpl_valid_i,
  input  logic [NUM_CPL-1:0][TAG_W-1:0]    cpl_tag_i,
  input  logic [NUM_CPL-1:0][VAL_W-1:0]    cpl_value_i,
  input  logic [NUM_CPL-1:0][FLAG_W-1:0]   cpl_flags_i,
  input  logic [1:0][TAG_W-1:0]            rd_tag_i,
  output logic [1:0]                       rd_done_o,
  output logic [1:0][VAL_W-1:0]            rd_value_o,
  output logic [1:0][FLAG_W-1:0]           rd_flags_o,
  output logic                             commit_valid_o,
  input  logic                             commit_ready_i,
  output logic [TAG_W-1:0]                 commit_tag_o,
  output logic [MGMT_W-1:0]                commit_mgmt_o,
  output logic [VAL_W-1:0]                 commit_value_o,
  output logic [FLAG_W-1:0]                commit_flags_o,
  input  logic                             flush_i,
  output logic [TAG_W:0]                   count_o,
  output logic                             full_o,
  output logic                             empty_o
);
  logic [TAG_W-1:0]                head, tail;
  logic [TAG_W:0]                  count;
  logic [ROB_SIZE-1:0]             busy, done;
  logic [ROB_SIZE-1:0][MGMT_W-1:0] mgmt;
  logic [ROB_SIZE-1:0][VAL_W-1:0]  value;
  logic [ROB_SIZE-1:0][FLAG_W-1:0] flags;

  logic [ROB_SIZE-1:0]             cplHit;
  logic [ROB_SIZE-1:0][VAL_W-1:0]  cplVal;
  logic [ROB_SIZE-1:0][FLAG_W-1:0] cplFlg;
  logic                            allocFire, commitFire;

  assign full_o         = (count == (TAG_W+1)'(ROB_SIZE));
  assign empty_o        = (count == '0);
  assign count_o        = count;
  assign alloc_ready_o  = !full_o;
  assign alloc_tag_o    = tail;
  assign commit_valid_o = busy[head] && done[head];
  assign commit_tag_o   = head;
  assign commit_mgmt_o  = mgmt[head];
  assign commit_value_o = value[head];
  assign commit_flags_o = flags[head];
  assign allocFire      = alloc_valid_i && alloc_ready_o;
  assign commitFire     = commit_valid_o && commit_ready_i;

  // Per-entry completion resolve; later ports overwrite earlier ones.
  always_comb begin
    cplHit = '0;
    cplVal = '0;
    cplFlg = '0;
    for (int e = 0; e < ROB_SIZE; e++) begin
      for (int p = 0; p < NUM_CPL; p++) begin
        if (cpl_valid_i[p] && cpl_tag_i[p] == TAG_W'(e)) begin
          cplHit[e] = 1'b1;
          cplVal[e] = cpl_value_i[p];
          cplFlg[e] = cpl_flags_i[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
      mgmt  <= '0;
      value <= '0;
      flags <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
    end else begin
      for (int e = 0; e < ROB_SIZE; e++) begin
        if (cplHit[e] && busy[e]) begin
          done[e]  <= 1'b1;
          value[e] <= cplVal[e];
          flags[e] <= cplFlg[e];
        end
      end
      // Allocation only hits a non-busy slot, so it never races a completion.
      if (allocFire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        mgmt[tail] <= alloc_mgmt_i;
        tail       <= tail + TAG_W'(1);
      end
      if (commitFire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + TAG_W'(1);
      end
      case ({allocFire, commitFire})
        2'b10:   count <= count + (TAG_W+1)'(1);
        2'b01:   count <= count - (TAG_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gRd
    rob_rd_lane #(
      .ROB_SIZE(ROB_SIZE), .VAL_W(VAL_W), .FLAG_W(FLAG_W),
      .NUM_CPL(NUM_CPL), .TAG_W(TAG_W)
    ) uRd (
      .rdTag    (rd_tag_i[g]),
      .busy     (busy),
      .done     (done),
      .value    (value),
      .flags    (flags),
      .cplValid (cpl_valid_i),
      .cplTag   (cpl_tag_i),
      .cplValue (cpl_value_i),
      .cplFlags (cpl_flags_i),
      .rdDone   (rd_done_o[g]),
      .rdValue  (rd_value_o[g]),
      .rdFlags  (rd_flags_o[g])
    );
  end
endmodule
